fu_issue_scheduler: RTL and testbench

Issue scheduler between the reservation stations and the functional units, downstream of the issue stage. Each cycle it picks at most one ready RS entry for each execution resource: ALU, multiplier and memory port. Selection is round-robin per resource. It tracks occupancy of the non-pipelined multiplier and returns per-entry clear strobes so the RS frees granted slots.

---
 rtl/fu_issue_scheduler.sv | 131 +++++++++++++
 tb/tb_fu_issue_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_scheduler.sv
// Issue scheduler: per-cycle round-robin selection of ready RS entries for the
// ALU, the non-pipelined multiplier and the memory port, with RS clear strobes.
module fu_issue_scheduler #(
  parameter  int unsigned NUM_RS   = 8,
  parameter  int unsigned MULT_LAT = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_RS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_RS-1:0] rs_ready,
  input  logic [NUM_RS-1:0] rs_is_mult,
  input  logic [NUM_RS-1:0] rs_is_mem,
  input  logic              alu_ready,
  input  logic              mem_ready,
  input  logic              flush,
  output logic              alu_issue_valid,
  output logic [IDX_W-1:0]  alu_issue_idx,
  output logic              mult_issue_valid,
  output logic [IDX_W-1:0]  mult_issue_idx,
  output logic              mem_issue_valid,
  output logic [IDX_W-1:0]  mem_issue_idx,
  output logic [NUM_RS-1:0] rs_clear,
  output logic              mult_busy,
  output logic [31:0]       issue_count
);

  localparam int unsigned CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  logic [IDX_W-1:0]  alu_ptr_q, alu_ptr_d;
  logic [IDX_W-1:0]  mult_ptr_q, mult_ptr_d;
  logic [IDX_W-1:0]  mem_ptr_q, mem_ptr_d;
  logic [CNT_W-1:0]  mult_cnt_q, mult_cnt_d;
  logic [31:0]       count_q, count_d;

  logic [NUM_RS-1:0] alu_req, mult_req, mem_req;
  logic [IDX_W:0]    alu_pick, mult_pick, mem_pick;
  logic              alu_gnt, mult_gnt, mem_gnt;
  logic [1:0]        gnt_sum;
  logic [32:0]       count_ext;

  // Returns {found, idx}: first requester at or after ptr, wrapping modulo NUM_RS.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_RS-1:0] req,
                                             input logic [IDX_W-1:0]  ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    mem_req   = rs_ready & rs_is_mem;
    mult_req  = rs_ready & rs_is_mult & ~rs_is_mem;
    alu_req   = rs_ready & ~rs_is_mult & ~rs_is_mem;

    alu_pick  = rr_pick(alu_req, alu_ptr_q);
    mult_pick = rr_pick(mult_req, mult_ptr_q);
    mem_pick  = rr_pick(mem_req, mem_ptr_q);

    alu_gnt   = alu_pick[IDX_W] && alu_ready && !flush;
    mult_gnt  = mult_pick[IDX_W] && (mult_cnt_q == '0) && !flush;
    mem_gnt   = mem_pick[IDX_W] && mem_ready && !flush;
  end

  always_comb begin
    alu_ptr_d  = alu_ptr_q;
    mult_ptr_d = mult_ptr_q;
    mem_ptr_d  = mem_ptr_q;
    if (flush) begin
      alu_ptr_d  = '0;
      mult_ptr_d = '0;
      mem_ptr_d  = '0;
    end else begin
      if (alu_gnt)  alu_ptr_d  = alu_pick[IDX_W-1:0]  + IDX_W'(1);
      if (mult_gnt) mult_ptr_d = mult_pick[IDX_W-1:0] + IDX_W'(1);
      if (mem_gnt)  mem_ptr_d  = mem_pick[IDX_W-1:0]  + IDX_W'(1);
    end

    // An in-flight multiply keeps counting down through a flush.
    mult_cnt_d = mult_cnt_q;
    if (mult_gnt)
      mult_cnt_d = CNT_W'(MULT_LAT - 1);
    else if (mult_cnt_q != '0)
      mult_cnt_d = mult_cnt_q - CNT_W'(1);

    gnt_sum   = {1'b0, alu_gnt} + {1'b0, mult_gnt} + {1'b0, mem_gnt};
    count_ext = {1'b0, count_q} + 33'(gnt_sum);
    count_d   = count_ext[32] ? '1 : count_ext[31:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_ptr_q  <= '0;
      mult_ptr_q <= '0;
      mem_ptr_q  <= '0;
      mult_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      alu_ptr_q  <= alu_ptr_d;
      mult_ptr_q <= mult_ptr_d;
      mem_ptr_q  <= mem_ptr_d;
      mult_cnt_q <= mult_cnt_d;
      count_q    <= count_d;
    end
  end

  // Grant outputs are masked by reset directly so they drop without a clock.
  always_comb begin
    alu_issue_valid  = alu_gnt && reset;
    mult_issue_valid = mult_gnt && reset;
    mem_issue_valid  = mem_gnt && reset;
    alu_issue_idx    = alu_issue_valid  ? alu_pick[IDX_W-1:0]  : '0;
    mult_issue_idx   = mult_issue_valid ? mult_pick[IDX_W-1:0] : '0;
    mem_issue_idx    = mem_issue_valid  ? mem_pick[IDX_W-1:0]  : '0;
    rs_clear = '0;
    if (alu_issue_valid)  rs_clear[alu_issue_idx]  = 1'b1;
    if (mult_issue_valid) rs_clear[mult_issue_idx] = 1'b1;
    if (mem_issue_valid)  rs_clear[mem_issue_idx]  = 1'b1;
    mult_busy   = (mult_cnt_q != '0);
    issue_count = count_q;
  end

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Directed bench for fu_issue_scheduler: expected outputs are queued as each
// step is driven and popped for comparison mid-cycle.
module tb_fu_issue_scheduler;

  logic       clock;
  logic       reset;
  logic [7:0] rs_ready, rs_is_mult, rs_is_mem;
  logic       alu_ready, mem_ready, flush;
  logic       alu_issue_valid, mult_issue_valid, mem_issue_valid;
  logic [2:0] alu_issue_idx, mult_issue_idx, mem_issue_idx;
  logic [7:0] rs_clear;
  logic       mult_busy;
  logic [31:0] issue_count;

  fu_issue_scheduler #(.NUM_RS(8), .MULT_LAT(4)) dut (
    .clock(clock), .reset(reset),
    .rs_ready(rs_ready), .rs_is_mult(rs_is_mult), .rs_is_mem(rs_is_mem),
    .alu_ready(alu_ready), .mem_ready(mem_ready), .flush(flush),
    .alu_issue_valid(alu_issue_valid), .alu_issue_idx(alu_issue_idx),
    .mult_issue_valid(mult_issue_valid), .mult_issue_idx(mult_issue_idx),
    .mem_issue_valid(mem_issue_valid), .mem_issue_idx(mem_issue_idx),
    .rs_clear(rs_clear), .mult_busy(mult_busy), .issue_count(issue_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int av; int ai; int mv; int mi; int ev; int ei;
    int clr; int busy; logic [31:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [7:0] rdy, input logic [7:0] mul, input logic [7:0] mem,
                       input logic ar, input logic mr, input logic fl);
    rs_ready = rdy; rs_is_mult = mul; rs_is_mem = mem;
    alu_ready = ar; mem_ready = mr; flush = fl;
  endtask

  task automatic push(input int av, input int ai, input int mv, input int mi,
                      input int ev, input int ei, input int clr, input int busy);
    exp_t e;
    e.av = av; e.ai = ai; e.mv = mv; e.mi = mi; e.ev = ev; e.ei = ei;
    e.clr = clr; e.busy = busy; e.cnt = exp_cnt;
    sbq.push_back(e);
    exp_cnt = exp_cnt + 32'(av + mv + ev);
  endtask

  task automatic check();
    exp_t e;
    #1;
    if (sbq.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sbq.pop_front();
      cmp("alu_valid",  32'(alu_issue_valid),  32'(e.av));
      cmp("alu_idx",    32'(alu_issue_idx),    32'(e.ai));
      cmp("mult_valid", 32'(mult_issue_valid), 32'(e.mv));
      cmp("mult_idx",   32'(mult_issue_idx),   32'(e.mi));
      cmp("mem_valid",  32'(mem_issue_valid),  32'(e.ev));
      cmp("mem_idx",    32'(mem_issue_idx),    32'(e.ei));
      cmp("rs_clear",   32'(rs_clear),         32'(e.clr));
      cmp("mult_busy",  32'(mult_busy),        32'(e.busy));
      cmp("issue_count", issue_count,          e.cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    drive(8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    #2;
    push(0, 0, 0, 0, 0, 0, 8'h00, 0);                 // held in reset: nothing
    check();
    @(negedge clock);
    reset = 1'b1;

    // Round-robin over eight ALU entries, wrapping back to 0
    for (int i = 0; i < 9; i++) begin
      drive(8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      push(1, i % 8, 0, 0, 0, 0, 1 << (i % 8), 0);
      check();
      @(negedge clock);
    end

    // Multiplier occupancy: entries 2 and 5 both MULT
    drive(8'h24, 8'h24, 8'h00, 1'b1, 1'b1, 1'b0);
    push(0, 0, 1, 2, 0, 0, 8'h04, 0);
    check(); @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      drive(8'h20, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0);
      push(0, 0, 0, 0, 0, 0, 8'h00, 1);
      check(); @(negedge clock);
    end
    drive(8'h20, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0);
    push(0, 0, 1, 5, 0, 0, 8'h20, 0);
    check(); @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      push(0, 0, 0, 0, 0, 0, 8'h00, (i < 3) ? 1 : 0);
      check(); @(negedge clock);
    end

    // Concurrent classes: ALU 1, MULT 3 (mult_ptr=6 wraps), MEM 6
    drive(8'h4A, 8'h08, 8'h40, 1'b1, 1'b1, 1'b0);
    push(1, 1, 1, 3, 1, 6, 8'h4A, 0);
    check(); @(negedge clock);

    // MEM+MULT overlap on entry 4 classifies as MEM; blocked, then granted
    drive(8'h10, 8'h10, 8'h10, 1'b1, 1'b0, 1'b0);
    push(0, 0, 0, 0, 0, 0, 8'h00, 1);
    check(); @(negedge clock);
    drive(8'h10, 8'h10, 8'h10, 1'b1, 1'b1, 1'b0);
    push(0, 0, 0, 0, 1, 4, 8'h10, 1);
    check(); @(negedge clock);

    // ALU backpressure
    drive(8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    push(0, 0, 0, 0, 0, 0, 8'h00, 1);
    check(); @(negedge clock);

    // Multiplier free again: grant entry 0 (mult_ptr=4 wraps), then mult_cnt=2
    drive(8'h01, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    push(0, 0, 1, 0, 0, 0, 8'h01, 0);
    check(); @(negedge clock);
    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    push(0, 0, 0, 0, 0, 0, 8'h00, 1);
    check(); @(negedge clock);

    // Flush with mem_ptr=5, alu_ptr=2, mult_cnt=2
    drive(8'hFF, 8'h00, 8'hF0, 1'b1, 1'b1, 1'b1);
    push(0, 0, 0, 0, 0, 0, 8'h00, 1);
    check(); @(negedge clock);
    drive(8'hFF, 8'h00, 8'hF0, 1'b1, 1'b1, 1'b0);
    push(1, 0, 0, 0, 1, 4, 8'h11, 1);                 // mult_cnt=1, searches from 0
    check(); @(negedge clock);

    // Async reset mid-multiply
    drive(8'h02, 8'h02, 8'h00, 1'b1, 1'b1, 1'b0);
    push(0, 0, 1, 1, 0, 0, 8'h02, 0);
    check(); @(negedge clock);
    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    push(0, 0, 0, 0, 0, 0, 8'h00, 1);                 // mult_cnt=3
    check();
    #1;
    reset = 1'b0;
    drive(8'hFF, 8'h04, 8'h80, 1'b1, 1'b1, 1'b0);
    exp_cnt = 0;
    push(0, 0, 0, 0, 0, 0, 8'h00, 0);
    check();
    @(negedge clock);
    reset = 1'b1;
    drive(8'h04, 8'h04, 8'h00, 1'b1, 1'b1, 1'b0);
    push(0, 0, 1, 2, 0, 0, 8'h04, 0);
    check(); @(negedge clock);
    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    push(0, 0, 0, 0, 0, 0, 8'h00, 1);
    check(); @(negedge clock);

    if (sbq.size() != 0) begin
      total++; bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
